keypoint_write_arbiter: RTL

//  Shares one keypoint SRAM write port between the two keypoint streams
//  (scale pair 0 and 1) produced by the detect/filter stage. Each stream is

---
 rtl/keypoint_write_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypoint_write_arbiter.sv
// Merges two buffered keypoint streams onto one SRAM write port (round-robin, source-tagged) and sequences a frame.
// Optional per-source write counters kp0_cnt/kp1_cnt: define KP_ARB_STATS_EN.
module keypoint_write_arbiter #(
  parameter int DATA_W     = 19,
  parameter int ADDR_W     = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_KP     = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              kp0_valid,
  input  logic [DATA_W-1:0] kp0_data,
  output logic              kp0_ready,
  input  logic              kp1_valid,
  input  logic [DATA_W-1:0] kp1_data,
  output logic              kp1_ready,
  output logic              kp_we,
  output logic [ADDR_W-1:0] kp_addr,
  output logic [DATA_W:0]   kp_din,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   kp_total,
  output logic              overflow
`ifdef KP_ARB_STATS_EN
  ,
  output logic [ADDR_W:0]   kp0_cnt,
  output logic [ADDR_W:0]   kp1_cnt
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_KP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic              overflow_r;
  logic              rr_ptr_r;
  logic [CNT_W-1:0]  wr_cnt_r;
  logic              kp_we_r;
  logic [ADDR_W-1:0] kp_addr_r;
  logic [DATA_W:0]   kp_din_r;
  logic              pend_v_r;
  logic              pend_src_r;
  logic [DATA_W-1:0] pend_data_r;
`ifdef KP_ARB_STATS_EN
  logic [CNT_W-1:0]  kp0_cnt_r;
  logic [CNT_W-1:0]  kp1_cnt_r;
`endif

  logic [DATA_W-1:0] fifo_mem_r [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wr_r  [2];
  logic [PTR_W-1:0]  fifo_rd_r  [2];
  logic [OCC_W-1:0]  fifo_occ_r [2];

  logic [1:0]        valid_s;
  logic [1:0]        ready_s;
  logic [1:0]        push_s;
  logic [1:0]        pop_s;
  logic [1:0]        nempty_s;
  logic [DATA_W-1:0] in_data_s [2];
  logic              serve_s;
  logic              grant_s;
  logic              sel_s;
  logic              frame_open_s;
  logic [DATA_W-1:0] grant_data_s;

  // Handshake, FIFO flags and round-robin grant selection
  always_comb begin
    valid_s      = {kp1_valid, kp0_valid};
    in_data_s[0] = kp0_data;
    in_data_s[1] = kp1_data;
    serve_s      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    frame_open_s = (state_r == ST_IDLE) && frame_start;
    for (int i = 0; i < 2; i++) begin
      nempty_s[i] = (fifo_occ_r[i] != {OCC_W{1'b0}});
      ready_s[i]  = (state_r == ST_RUN) && (fifo_occ_r[i] != OCC_FULL);
      push_s[i]   = valid_s[i] && ready_s[i];
    end
    if (nempty_s == 2'b11) begin
      sel_s = rr_ptr_r;
    end else begin
      sel_s = nempty_s[1];
    end
    grant_s = serve_s && (nempty_s != 2'b00);
    pop_s   = 2'b00;
    if (grant_s) begin
      pop_s[sel_s] = 1'b1;
    end else begin
      pop_s = 2'b00;
    end
    grant_data_s = fifo_mem_r[sel_s][fifo_rd_r[sel_s]];
  end

  // FIFO storage; occupancy gates every read, so contents need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) begin
        fifo_mem_r[i][fifo_wr_r[i]] <= in_data_s[i];
      end
    end
  end

  // FIFO pointers and occupancy, emptied on reset and on frame entry
  always_ff @(posedge clk) begin
    if (rst || frame_open_s) begin
      for (int i = 0; i < 2; i++) begin
        fifo_wr_r[i]  <= {PTR_W{1'b0}};
        fifo_rd_r[i]  <= {PTR_W{1'b0}};
        fifo_occ_r[i] <= {OCC_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i]) begin
          fifo_wr_r[i] <= fifo_wr_r[i] + PTR_W'(1'b1);
        end
        if (pop_s[i]) begin
          fifo_rd_r[i] <= fifo_rd_r[i] + PTR_W'(1'b1);
        end
        fifo_occ_r[i] <= fifo_occ_r[i] + OCC_W'(push_s[i]) - OCC_W'(pop_s[i]);
      end
    end
  end

  // Frame sequencing, pop stage and SRAM write stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
      rr_ptr_r    <= 1'b0;
      wr_cnt_r    <= {CNT_W{1'b0}};
      kp_we_r     <= 1'b0;
      kp_addr_r   <= {ADDR_W{1'b0}};
      kp_din_r    <= {(DATA_W+1){1'b0}};
      pend_v_r    <= 1'b0;
      pend_src_r  <= 1'b0;
      pend_data_r <= {DATA_W{1'b0}};
`ifdef KP_ARB_STATS_EN
      kp0_cnt_r   <= {CNT_W{1'b0}};
      kp1_cnt_r   <= {CNT_W{1'b0}};
`endif
    end else begin
      pend_v_r <= grant_s;
      if (grant_s) begin
        pend_src_r  <= sel_s;
        pend_data_r <= grant_data_s;
        rr_ptr_r    <= ~sel_s;
      end
      // A record popped once memory is full is dropped and flagged
      kp_we_r <= 1'b0;
      if (pend_v_r) begin
        if (wr_cnt_r < CNT_MAX) begin
          kp_we_r   <= 1'b1;
          kp_addr_r <= wr_cnt_r[ADDR_W-1:0];
          kp_din_r  <= {pend_src_r, pend_data_r};
          wr_cnt_r  <= wr_cnt_r + CNT_W'(1'b1);
`ifdef KP_ARB_STATS_EN
          if (pend_src_r) begin
            if (kp1_cnt_r < CNT_MAX) kp1_cnt_r <= kp1_cnt_r + CNT_W'(1'b1);
          end else begin
            if (kp0_cnt_r < CNT_MAX) kp0_cnt_r <= kp0_cnt_r + CNT_W'(1'b1);
          end
`endif
        end else begin
          overflow_r <= 1'b1;
        end
      end
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (frame_start) begin
            state_r    <= ST_RUN;
            busy_r     <= 1'b1;
            wr_cnt_r   <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
`ifdef KP_ARB_STATS_EN
            kp0_cnt_r  <= {CNT_W{1'b0}};
            kp1_cnt_r  <= {CNT_W{1'b0}};
`endif
          end
        end
        ST_RUN: begin
          if (frame_end) state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((nempty_s == 2'b00) && !pend_v_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign kp0_ready = ready_s[0];
  assign kp1_ready = ready_s[1];
  assign kp_we     = kp_we_r;
  assign kp_addr   = kp_addr_r;
  assign kp_din    = kp_din_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign kp_total  = wr_cnt_r;
  assign overflow  = overflow_r;
`ifdef KP_ARB_STATS_EN
  assign kp0_cnt   = kp0_cnt_r;
  assign kp1_cnt   = kp1_cnt_r;
`endif

endmodule
